// File: rtl/pb_fb_arbiter_rr.sv
// pb_fb_arbiter_rr: N-channel frontend-bus arbiter.
// Merges NCH master channels onto a single mbus toward the L2 cache.
// Arbitration is round-robin or fixed-priority, and only one transaction is outstanding at a time.
// The grant register is one-hot and changes only when the FSM enters CMD.
// A completed response can hand the bus straight to the next requester without an idle cycle.
module pb_fb_arbiter_rr #(
  parameter int NCH        = 3,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        fb_s_AVALID,
  output logic [NCH-1:0]        fb_s_AREADY,
  input  logic [NCH*AW-1:0]     fb_s_AADDR,
  input  logic [NCH*DW-1:0]     fb_s_ADATA,
  input  logic [NCH*DW/8-1:0]   fb_s_AWMSK,
  input  logic [NCH*2-1:0]      fb_s_AEXC,
  output logic [NCH-1:0]        fb_s_BVALID,
  input  logic [NCH-1:0]        fb_s_BREADY,
  output logic [DW-1:0]         fb_s_BDATA,
  output logic [1:0]            fb_s_BEXC,
  output logic                  fb_mbus_AVALID,
  input  logic                  fb_mbus_AREADY,
  output logic [AW-1:0]         fb_mbus_AADDR,
  output logic [DW-1:0]         fb_mbus_ADATA,
  output logic [DW/8-1:0]       fb_mbus_AWMSK,
  output logic [1:0]            fb_mbus_AEXC,
  input  logic                  fb_mbus_BVALID,
  output logic                  fb_mbus_BREADY,
  input  logic [DW-1:0]         fb_mbus_BDATA,
  input  logic [1:0]            fb_mbus_BEXC,
  output logic [NCH-1:0]        fb_grant
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [PW-1:0]  ptr_q, ptr_d;

  logic [PW-1:0]  ptr_next;
  logic [PW-1:0]  scan_base;
  logic [NCH-1:0] win_oh;
  logic           win_found;
  logic           any_req;
  logic           b_ready_sel;
  logic           b_fire;

  // Pointer value after the current owner completes: one past the owner, wrapping at NCH-1.
  always_comb begin
    ptr_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q[i]) begin
        ptr_next = (i == NCH - 1) ? PW'(0) : PW'(i + 1);
      end
    end
  end

  // A re-arbitration on the completing edge must already use the advanced pointer, otherwise the finishing channel would win again.
  assign scan_base = (state_q == S_RESP) ? ptr_next : ptr_q;
  assign any_req   = |fb_s_AVALID;

  // Winner selection: either the lowest asserted index, or the first asserted index scanning upward from the pointer with wrap.
  always_comb begin
    win_oh    = '0;
    win_found = 1'b0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (!win_found && fb_s_AVALID[i]) begin
          win_oh[i] = 1'b1;
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        for (int i = 0; i < NCH; i++) begin
          if (!win_found && fb_s_AVALID[i] &&
              (((int'(scan_base) + k) % NCH) == i)) begin
            win_oh[i] = 1'b1;
            win_found = 1'b1;
          end
        end
      end
    end
  end

  // The owner's BREADY is the only one that may complete a response.
  assign b_ready_sel = |(grant_q & fb_s_BREADY);
  assign b_fire      = (state_q == S_RESP) && fb_mbus_BVALID && b_ready_sel;

  // Next-state logic: the grant is loaded only when entering CMD, and the pointer moves only on completed transactions.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = win_oh;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (fb_mbus_AREADY) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (b_fire) begin
          ptr_d = ptr_next;
          if (any_req) begin
            grant_d = win_oh;
            state_d = S_CMD;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Command payload is an AND-OR mux on the one-hot grant, so it is zero whenever nobody owns the bus.
  always_comb begin
    fb_mbus_AADDR = '0;
    fb_mbus_ADATA = '0;
    fb_mbus_AWMSK = '0;
    fb_mbus_AEXC  = '0;
    for (int i = 0; i < NCH; i++) begin
      fb_mbus_AADDR = fb_mbus_AADDR | (fb_s_AADDR[i*AW +: AW] & {AW{grant_q[i]}});
      fb_mbus_ADATA = fb_mbus_ADATA | (fb_s_ADATA[i*DW +: DW] & {DW{grant_q[i]}});
      fb_mbus_AWMSK = fb_mbus_AWMSK | (fb_s_AWMSK[i*MW +: MW] & {MW{grant_q[i]}});
      fb_mbus_AEXC  = fb_mbus_AEXC  | (fb_s_AEXC[i*2 +: 2]    & {2{grant_q[i]}});
    end
  end

  // Handshake steering: only the owner sees ready or valid, and only in the matching phase.
  always_comb begin
    fb_mbus_AVALID = (state_q == S_CMD);
    fb_s_AREADY    = '0;
    fb_s_BVALID    = '0;
    fb_mbus_BREADY = 1'b0;
    fb_s_BDATA     = '0;
    fb_s_BEXC      = '0;
    if (state_q == S_CMD) begin
      fb_s_AREADY = grant_q & {NCH{fb_mbus_AREADY}};
    end
    if (state_q == S_RESP) begin
      fb_s_BVALID    = grant_q & {NCH{fb_mbus_BVALID}};
      fb_mbus_BREADY = b_ready_sel;
      fb_s_BDATA     = fb_mbus_BDATA;
      fb_s_BEXC      = fb_mbus_BEXC;
    end
  end

  assign fb_grant = grant_q;

endmodule
